// File: rtl/mbist_march_ctrl.sv
// March C- BIST sequencer: issues ops to a memory with registered wdata and a
// two-stage read path, checks the returned words and records failure status.
module mbist_march_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4,
    parameter int CAPACITY   = 15,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic                  fail,
    output logic [ADDR_WIDTH-1:0] fail_addr,
    output logic [2:0]            fail_elem,
    output logic [CNT_WIDTH-1:0]  fail_count,
    output logic                  write_read,
    output logic [ADDR_WIDTH-1:0] address,
    output logic [DATA_WIDTH-1:0] wdata,
    input  logic [DATA_WIDTH-1:0] rdata
);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_PRE   = 3'd1;
    localparam logic [2:0] ST_RUN   = 3'd2;
    localparam logic [2:0] ST_DRAIN = 3'd3;
    localparam logic [2:0] ST_FIN   = 3'd4;

    localparam logic [ADDR_WIDTH-1:0] ADDR_LAST = ADDR_WIDTH'(CAPACITY);
    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = ADDR_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0]  CNT_ONE   = CNT_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0]  CNT_MAX   = {CNT_WIDTH{1'b1}};
    localparam int PIPE_DEPTH = 3;

    // Elements 1..4 issue a read then a write at each address.
    function automatic logic elem_paired(input logic [2:0] e);
        return (e >= 3'd1) && (e <= 3'd4);
    endfunction

    function automatic logic elem_desc(input logic [2:0] e);
        return (e == 3'd3) || (e == 3'd4);
    endfunction

    function automatic logic op_is_write(input logic [2:0] e, input logic ph);
        return (e == 3'd0) || (elem_paired(e) && ph);
    endfunction

    // Background of an op: written value for writes, expected value for reads.
    function automatic logic op_ones(input logic [2:0] e, input logic ph);
        if (op_is_write(e, ph)) return (e == 3'd1) || (e == 3'd3);
        return (e == 3'd2) || (e == 3'd4);
    endfunction

    logic [2:0]            state_reg;
    logic                  busy_reg, done_reg, fail_reg;
    logic [ADDR_WIDTH-1:0] fail_addr_reg;
    logic [2:0]            fail_elem_reg;
    logic [CNT_WIDTH-1:0]  fail_count_reg;
    logic                  write_read_reg;
    logic [ADDR_WIDTH-1:0] address_reg;
    logic [DATA_WIDTH-1:0] wdata_reg;

    // Op iterator: describes the op to be presented at the next edge.
    logic [2:0]            it_elem_reg, it_elem_next;
    logic [ADDR_WIDTH-1:0] it_addr_reg, it_addr_next;
    logic                  it_phase_reg, it_phase_next;
    logic                  it_end_reg, it_end_next;

    logic                  pipe_valid_reg [PIPE_DEPTH];
    logic [ADDR_WIDTH-1:0] pipe_addr_reg  [PIPE_DEPTH];
    logic [2:0]            pipe_elem_reg  [PIPE_DEPTH];
    logic [DATA_WIDTH-1:0] pipe_exp_reg   [PIPE_DEPTH];

    logic cur_write, cur_ones, next_write, next_ones, at_range_end, miscompare;

    always_comb begin
        it_elem_next  = it_elem_reg;
        it_addr_next  = it_addr_reg;
        it_phase_next = it_phase_reg;
        it_end_next   = it_end_reg;
        at_range_end  = elem_desc(it_elem_reg) ? (it_addr_reg == '0) : (it_addr_reg == ADDR_LAST);
        if (elem_paired(it_elem_reg) && !it_phase_reg) begin
            it_phase_next = 1'b1;
        end else begin
            it_phase_next = 1'b0;
            if (at_range_end) begin
                if (it_elem_reg == 3'd5) begin
                    it_end_next = 1'b1;
                end else begin
                    it_elem_next = it_elem_reg + 3'd1;
                    it_addr_next = elem_desc(it_elem_next) ? ADDR_LAST : '0;
                end
            end else begin
                it_addr_next = elem_desc(it_elem_reg) ? (it_addr_reg - ADDR_ONE) : (it_addr_reg + ADDR_ONE);
            end
        end
    end

    assign cur_write  = op_is_write(it_elem_reg, it_phase_reg);
    assign cur_ones   = op_ones(it_elem_reg, it_phase_reg);
    assign next_write = op_is_write(it_elem_next, it_phase_next);
    assign next_ones  = op_ones(it_elem_next, it_phase_next);
    assign miscompare = pipe_valid_reg[PIPE_DEPTH-1] && (rdata != pipe_exp_reg[PIPE_DEPTH-1]);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg      <= ST_IDLE;
            busy_reg       <= 1'b0;
            done_reg       <= 1'b0;
            fail_reg       <= 1'b0;
            fail_addr_reg  <= '0;
            fail_elem_reg  <= '0;
            fail_count_reg <= '0;
            write_read_reg <= 1'b0;
            address_reg    <= '0;
            wdata_reg      <= '0;
            it_elem_reg    <= '0;
            it_addr_reg    <= '0;
            it_phase_reg   <= 1'b0;
            it_end_reg     <= 1'b0;
            for (int i = 0; i < PIPE_DEPTH; i++) begin
                pipe_valid_reg[i] <= 1'b0;
                pipe_addr_reg[i]  <= '0;
                pipe_elem_reg[i]  <= '0;
                pipe_exp_reg[i]   <= '0;
            end
        end else begin
            for (int i = 1; i < PIPE_DEPTH; i++) begin
                pipe_valid_reg[i] <= pipe_valid_reg[i-1];
                pipe_addr_reg[i]  <= pipe_addr_reg[i-1];
                pipe_elem_reg[i]  <= pipe_elem_reg[i-1];
                pipe_exp_reg[i]   <= pipe_exp_reg[i-1];
            end
            pipe_valid_reg[0] <= 1'b0;

            if (miscompare) begin
                fail_reg <= 1'b1;
                if (!fail_reg) begin
                    fail_addr_reg <= pipe_addr_reg[PIPE_DEPTH-1];
                    fail_elem_reg <= pipe_elem_reg[PIPE_DEPTH-1];
                end
                if (fail_count_reg != CNT_MAX) fail_count_reg <= fail_count_reg + CNT_ONE;
            end

            case (state_reg)
                ST_IDLE: begin
                    if (start) begin
                        state_reg      <= ST_PRE;
                        busy_reg       <= 1'b1;
                        done_reg       <= 1'b0;
                        fail_reg       <= 1'b0;
                        fail_addr_reg  <= '0;
                        fail_elem_reg  <= '0;
                        fail_count_reg <= '0;
                        wdata_reg      <= '0;
                        it_elem_reg    <= '0;
                        it_addr_reg    <= '0;
                        it_phase_reg   <= 1'b0;
                        it_end_reg     <= 1'b0;
                    end
                end
                ST_PRE, ST_RUN: begin
                    if (!it_end_reg) begin
                        state_reg         <= ST_RUN;
                        write_read_reg    <= cur_write;
                        address_reg       <= it_addr_reg;
                        pipe_valid_reg[0] <= !cur_write;
                        pipe_addr_reg[0]  <= it_addr_reg;
                        pipe_elem_reg[0]  <= it_elem_reg;
                        pipe_exp_reg[0]   <= {DATA_WIDTH{cur_ones}};
                        it_elem_reg       <= it_elem_next;
                        it_addr_reg       <= it_addr_next;
                        it_phase_reg      <= it_phase_next;
                        it_end_reg        <= it_end_next;
                        // wdata runs one op ahead; reads leave it untouched.
                        if (next_write && !it_end_next) wdata_reg <= {DATA_WIDTH{next_ones}};
                    end else begin
                        state_reg      <= ST_DRAIN;
                        write_read_reg <= 1'b0;
                        address_reg    <= '0;
                    end
                end
                ST_DRAIN: begin
                    // Only the oldest stage left: this edge performs the final compare.
                    if (!pipe_valid_reg[0] && !pipe_valid_reg[1]) begin
                        state_reg <= ST_FIN;
                        done_reg  <= 1'b1;
                        busy_reg  <= 1'b0;
                    end
                end
                ST_FIN: state_reg <= ST_IDLE;
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    assign busy       = busy_reg;
    assign done       = done_reg;
    assign fail       = fail_reg;
    assign fail_addr  = fail_addr_reg;
    assign fail_elem  = fail_elem_reg;
    assign fail_count = fail_count_reg;
    assign write_read = write_read_reg;
    assign address    = address_reg;
    assign wdata      = wdata_reg;

endmodule

// File: doc/mbist_march_ctrl.md
Name: mbist_march_ctrl

Overview:
- March C- BIST engine directly upstream of the fault-injected memory model.
- Drives the memory's write_read/address/wdata and checks the registered rdata it returns.
- Reports pass/fail, first failing address/element and a saturating fail count to the test top.
- Sequence: ⇕(w0); ⇑(r0,w1); ⇑(r1,w0); ⇓(r0,w1); ⇓(r1,w0); ⇕(r0). Element indices 0..5; all-zero/all-one word backgrounds.

Parameters:
- DATA_WIDTH, 8, memory word width.
- ADDR_WIDTH, 4, memory address width.
- CAPACITY, 15, highest memory address; the test covers addresses 0..CAPACITY inclusive.
- CNT_WIDTH, 8, width of the fail counter.

Ports:
- clk  in  1  sole clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  level; sampled only in IDLE.
- busy  out  1  high from the start edge until done.
- done  out  1  sticky; high after the final compare until the next accepted start or rst.
- fail  out  1  sticky; any miscompare in the current run.
- fail_addr  out  ADDR_WIDTH  address of the first miscompare.
- fail_elem  out  3  march element (0..5) of the first miscompare.
- fail_count  out  CNT_WIDTH  number of miscompared reads; saturates at all-ones.
- write_read  out  1  to memory: 1 = write, 0 = read.
- address  out  ADDR_WIDTH  to memory.
- wdata  out  DATA_WIDTH  to memory; leads its write op by one cycle.
- rdata  in  DATA_WIDTH  from memory.

Behaviour:
- Reset values: all outputs 0; write_read = 0 (read) and address = 0 when not running.
- The memory registers wdata one cycle before use. wdata at cycle t carries the pattern of the op presented on address/write_read at cycle t+1. Before a read op, wdata holds its previous value.
- FSM states IDLE, PRE, RUN, DRAIN, FIN.
- IDLE, start=1 at edge E: go to PRE. Set busy=1; clear done, fail, fail_addr, fail_elem, fail_count. Load wdata=0.
- PRE, edge E+1: go to RUN and present op 0 (addr 0, write).
- RUN: one op per cycle, no bubbles. Element 0 and element 5 issue one op per address. Elements 1..4 issue the read, then the write, at each address before stepping the address.
- Address direction: ascending 0..CAPACITY for elements 0, 1, 2 and 5; descending CAPACITY..0 for elements 3 and 4. Address wraps from the range end to the start of the next element with no idle cycle.
- Total ops = 10*(CAPACITY+1). The last op is presented after edge E+10*(CAPACITY+1).
- Read check: a read presented after edge k is compared at edge k+3, accounting for the memory's two rdata registers. A 3-deep pipeline carries valid, address, element and expected word.
- Expected word: all-zero for r0, all-one for r1. Any bit difference is a miscompare.
- Miscompare: set fail. If this is the first miscompare, capture fail_addr and fail_elem. Increment fail_count unless it is all-ones.
- DRAIN: runs after the last op. write_read=0, address=0, until the pipeline empties.
- FIN: entered at edge E+10*(CAPACITY+1)+3, which is also the final compare edge. Sets done=1 and busy=0, then returns to IDLE. Status holds until the next start.
- start while busy: ignored.
- start held high: a new run starts on the first edge in IDLE after done.
- rst mid-run: immediate return to IDLE; all outputs at reset values; no stale compares after release.
- A simultaneous final miscompare and done are both reported on the same edge.

Test Plan:
- Fault-free memory model, CAPACITY=15, start pulse at edge E -> done rises at edge E+163; fail=0, fail_count=0; busy high for exactly 163 cycles.
- Bit 0 of addr 5 stuck-at-0 -> fail=1, fail_addr=5, fail_elem=2 (first r1), fail_count=2 (elements 2 and 4).
- Neighbourhood fault on addr 6 (bit 5 of word 6 blocked when the neighbour pattern matches) -> fail=1, fail_addr=6, fail_count ≥1; write-data timing verified by a fault-free run with the same bench.
- start pulses at E+10 and E+50 during a run -> ignored; done still at E+163 and sequence unchanged.
- rst asserted at E+40 for 2 cycles, then start -> outputs 0 during reset; the new run completes cleanly with fail=0.
- CNT_WIDTH=2, all words stuck-at-1 -> fail_count saturates at 3, fail_addr=0, fail_elem=1.
